// File: rtl/tb_conv_encoder_param.sv
// Tail-biting rate-1/3 convolutional encoder with runtime block length.
// A code block arrives as a byte stream (MSB first) and is buffered. The
// last K-1 bits seed the shift register, then one {d2,d1,d0} symbol is
// emitted per accepted output cycle.
module tb_conv_encoder_param #(
    parameter int           K         = 7,
    parameter logic [K-1:0] G0        = 7'o133,
    parameter logic [K-1:0] G1        = 7'o171,
    parameter logic [K-1:0] G2        = 7'o165,
    parameter int           MAX_BYTES = 768,
    parameter int           LEN_W     = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] blk_len,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_d,
    output logic             out_first,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int SW = K - 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ENCODE = 2'd2
    } state_t;

    // One output bit: current input bit on the top tap, sr[j] on tap K-2-j.
    function automatic logic tap_parity(input logic [K-1:0] g, input logic [SW-1:0] s,
                                        input logic c);
        logic p;
        p = g[K-1] & c;
        for (int j = 0; j < SW; j++) begin
            p = p ^ (g[K-2-j] & s[j]);
        end
        return p;
    endfunction

    function automatic logic [2:0] encode(input logic [SW-1:0] s, input logic c);
        return {tap_parity(G2, s, c), tap_parity(G1, s, c), tap_parity(G0, s, c)};
    endfunction

    state_t           state;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] count;
    logic [LEN_W-1:0] byte_idx;
    logic [2:0]       bit_pos;
    logic [SW-1:0]    hist;
    logic [SW-1:0]    sr;

    logic [7:0]       buffer [MAX_BYTES];
    logic [7:0]       first_byte;
    logic [7:0]       rd_data;
    logic [7:0]       cur_byte;

    logic [SW-1:0]    hist_next;
    logic [SW-1:0]    sr_next;
    logic             c_next;
    logic [LEN_W-1:0] idx_next;
    logic [2:0]       pos_next;
    logic [LEN_W-1:0] rd_addr;
    logic [LEN_W-1:0] last_idx;
    logic             len_ok;

    // Newest bits of the stream land in the low end; bit 0 is the block's final bit.
    assign hist_next = SW'({hist, in_data});
    // cur_byte is shifted left on every transfer, so bit 7 is always c_k.
    assign sr_next   = {sr[SW-2:0], cur_byte[7]};
    assign c_next    = (bit_pos == 3'd7) ? rd_data[7] : cur_byte[6];
    assign idx_next  = (bit_pos == 3'd7) ? byte_idx + 1'b1 : byte_idx;
    assign pos_next  = bit_pos + 3'd1;
    // The read port always prefetches the byte after the one being encoded.
    assign rd_addr   = byte_idx + 1'b1;
    assign last_idx  = len - 1'b1;
    assign len_ok    = (blk_len != '0) && (blk_len <= MAX_LEN);

    assign in_ready  = (state == LOAD);
    assign busy      = (state != IDLE);

    // Control FSM: block intake, tail-biting seed, symbol generation with backpressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            len       <= '0;
            count     <= '0;
            byte_idx  <= '0;
            bit_pos   <= '0;
            hist      <= '0;
            sr        <= '0;
            out_valid <= 1'b0;
            out_d     <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            state <= LOAD;
                            len   <= blk_len;
                            count <= '0;
                            hist  <= '0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        count <= count + 1'b1;
                        hist  <= hist_next;
                        if (count == last_idx) begin
                            state    <= ENCODE;
                            sr       <= hist_next;
                            byte_idx <= '0;
                            bit_pos  <= '0;
                        end
                    end
                end
                ENCODE: begin
                    if (!out_valid) begin
                        // Read stage done: present symbol 0 from the seeded register.
                        out_valid <= 1'b1;
                        out_d     <= encode(sr, first_byte[7]);
                        out_first <= 1'b1;
                        out_last  <= 1'b0;
                    end else if (out_ready) begin
                        sr <= sr_next;
                        if (out_last) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_d     <= '0;
                            out_first <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            byte_idx  <= idx_next;
                            bit_pos   <= pos_next;
                            out_d     <= encode(sr_next, c_next);
                            out_first <= 1'b0;
                            out_last  <= (idx_next == last_idx) && (pos_next == 3'd7);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Block buffer: write during intake, registered prefetch read during encoding.
    always_ff @(posedge clk) begin
        if (state == LOAD && in_valid) begin
            buffer[count] <= in_data;
            if (count == '0) begin
                first_byte <= in_data;
            end
        end
        if (rd_addr < MAX_LEN) begin
            rd_data <= buffer[rd_addr];
        end
    end

    // Working byte: loaded with byte 0 at start, shifted per transfer, refilled at byte edges.
    always_ff @(posedge clk) begin
        if (state == ENCODE) begin
            if (!out_valid) begin
                cur_byte <= first_byte;
            end else if (out_ready) begin
                cur_byte <= (bit_pos == 3'd7) ? rd_data : {cur_byte[6:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_tb_conv_encoder_param.sv
// Bench for tb_conv_encoder_param: each block's symbols are predicted as a
// circular convolution of the whole block with the generators, and every
// transferred symbol, stall, done pulse and latency point is checked.
module tb_tb_conv_encoder_param;
    localparam int K     = 7;
    localparam int LEN_W = 10;

    typedef struct {
        logic [2:0] d;
        logic       first;
        logic       last;
    } sym_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [LEN_W-1:0] blk_len;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       out_d;
    logic             out_first;
    logic             out_last;
    logic             busy;
    logic             done;
    logic             err;

    tb_conv_encoder_param dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .blk_len   (blk_len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_d     (out_d),
        .out_first (out_first),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    sym_t       exp_q [$];
    logic [2:0] got_q [$];
    logic [7:0] blk   [$];
    logic [6:0] gens  [3];
    logic [K-2:0] sr_exp;
    bit         check_en = 1'b0;
    bit         rand_rdy = 1'b0;
    bit         stall_prev = 1'b0;
    bit         done_due = 1'b0;
    logic [4:0] held;
    int         xfer_cnt = 0;
    int         done_cnt = 0;

    int seq80 [8] = '{7, 6, 7, 3, 4, 1, 7, 0};
    int seq01 [8] = '{6, 7, 3, 4, 1, 7, 0, 7};
    int seqff [8] = '{7, 7, 7, 7, 7, 7, 7, 7};
    int seq00 [8] = '{0, 0, 0, 0, 0, 0, 0, 0};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    // Symbol k uses bit k on the top tap and the K-1 preceding bits of the
    // block taken circularly, which is exactly what tail-biting means.
    function automatic void build_model();
        int n;
        bit c [];
        n = 8 * blk.size();
        c = new[n];
        for (int k = 0; k < n; k++) c[k] = blk[k / 8][7 - (k % 8)];
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            sym_t s;
            logic [2:0] d;
            for (int i = 0; i < 3; i++) begin
                logic [6:0] g;
                logic p;
                g = gens[i];
                p = g[K-1] & c[k];
                for (int j = 0; j < K - 1; j++) p ^= g[K-2-j] & c[(k - 1 - j + n) % n];
                d[i] = p;
            end
            s.d = d;
            s.first = (k == 0);
            s.last = (k == n - 1);
            exp_q.push_back(s);
        end
        for (int j = 0; j < K - 1; j++) sr_exp[j] = c[n - 1 - j];
    endfunction

    // Compare process: symbols on transfer, stability on stall, done timing.
    always @(negedge clk) begin
        sym_t e;
        if (check_en) begin
            if (stall_prev && out_valid)
                chk("stall_hold", {27'd0, out_first, out_last, out_d}, {27'd0, held});
            if (done_due || done) chk("done_pulse", done, done_due);
            if (done_due) chk("valid_drop", out_valid, 0);
            if (done) done_cnt++;
            done_due = 1'b0;
            if (out_valid && out_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    chk("extra_symbol", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_d", out_d, e.d);
                    chk("out_first", out_first, e.first);
                    chk("out_last", out_last, e.last);
                    got_q.push_back(out_d);
                    done_due = e.last;
                end
            end
            stall_prev = out_valid && !out_ready;
            held = {out_first, out_last, out_d};
        end else begin
            stall_prev = 1'b0;
            done_due = 1'b0;
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic start_pulse(input logic [LEN_W-1:0] len);
        start = 1'b1;
        blk_len = len;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic feed(input bit gaps);
        foreach (blk[i]) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data = blk[i];
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic run_block(input bit rr, input bit gaps);
        int d0;
        int t;
        build_model();
        got_q.delete();
        rand_rdy = rr;
        xfer_cnt = 0;
        start_pulse(LEN_W'(blk.size()));
        @(negedge clk);
        chk("busy_load", busy, 1);
        chk("in_ready_load", in_ready, 1);
        d0 = done_cnt;
        feed(gaps);
        @(negedge clk);
        chk("latency_t1", out_valid, 0);
        @(negedge clk);
        chk("latency_t2", out_valid, 1);
        t = 0;
        while (done_cnt == d0 && t < 20000) begin
            @(posedge clk);
            t++;
        end
        chk("done_seen", done_cnt - d0, 1);
        chk("symbols_left", exp_q.size(), 0);
        @(negedge clk);
        chk("busy_idle", busy, 0);
        chk("sr_tailbite", dut.sr, sr_exp);
        @(posedge clk);
        #1;
    endtask

    task automatic check_seq(input string nm, input int e [8]);
        chk({nm, "_count"}, got_q.size(), 8);
        for (int i = 0; i < 8 && i < got_q.size(); i++) chk(nm, got_q[i], e[i]);
    endtask

    initial begin
        int t;
        int n;
        gens[0] = 7'o133;
        gens[1] = 7'o171;
        gens[2] = 7'o165;
        reset = 1'b1;
        start = 1'b0;
        blk_len = '0;
        in_valid = 1'b0;
        in_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_d", out_d, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        reset = 1'b0;
        check_en = 1'b1;
        @(posedge clk);
        #1;

        blk = '{8'h80};
        run_block(1'b0, 1'b0);
        check_seq("seq_80", seq80);
        blk = '{8'h01};
        run_block(1'b0, 1'b0);
        check_seq("seq_01", seq01);
        chk("sr_seed_01", dut.sr, 1);
        blk = '{8'hFF};
        run_block(1'b0, 1'b0);
        check_seq("seq_ff", seqff);
        blk = '{8'h00};
        run_block(1'b0, 1'b0);
        check_seq("seq_00", seq00);

        start_pulse(10'd0);
        @(negedge clk);
        chk("err_len0", err, 1);
        chk("err_len0_busy", busy, 0);
        chk("err_len0_in_ready", in_ready, 0);
        @(negedge clk);
        chk("err_len0_clear", err, 0);
        @(posedge clk);
        #1;
        start_pulse(10'd769);
        @(negedge clk);
        chk("err_len769", err, 1);
        chk("err_len769_busy", busy, 0);
        chk("err_len769_in_ready", in_ready, 0);
        @(negedge clk);
        chk("err_len769_clear", err, 0);
        @(posedge clk);
        #1;

        for (int b = 0; b < 4; b++) begin
            blk.delete();
            n = $urandom_range(1, 24);
            for (int i = 0; i < n; i++) blk.push_back(8'($urandom));
            run_block(1'b1, 1'b1);
        end

        blk.delete();
        for (int i = 0; i < 768; i++) blk.push_back(8'($urandom));
        run_block(1'b1, 1'b1);

        blk.delete();
        for (int i = 0; i < 20; i++) blk.push_back(8'($urandom));
        build_model();
        rand_rdy = 1'b1;
        xfer_cnt = 0;
        start_pulse(10'd20);
        feed(1'b0);
        t = 0;
        while (xfer_cnt < 100 && t < 5000) begin
            @(posedge clk);
            t++;
        end
        chk("reach_sym100", xfer_cnt, 100);
        #2;
        check_en = 1'b0;
        reset = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check_en = 1'b1;
        blk = '{8'h80};
        run_block(1'b0, 1'b0);
        check_seq("seq_80_after_reset", seq80);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
